// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the Wishbone SPI controller:
//   - register addresses on wb_adr_i
//   - STATUS register bit positions
//   - FSM state encoding
//   - a helper that packs the STATUS byte
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam logic [1:0] SPI_REG_DATA    = 2'd0;
    localparam logic [1:0] SPI_REG_STATUS  = 2'd1;
    localparam logic [1:0] SPI_REG_CONTROL = 2'd2;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_BUSY     = 4;
    localparam int STAT_OVR      = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        LOW  = 3'd2,
        HIGH = 3'd3,
        DONE = 3'd4
    } state_t;

    // Assemble the STATUS byte; bits 7:6 read as zero.
    function automatic logic [7:0] pack_status(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_full,
        input logic rx_empty,
        input logic busy,
        input logic ovr
    );
        logic [7:0] v;
        v                = 8'h00;
        v[STAT_TX_FULL]  = tx_full;
        v[STAT_TX_EMPTY] = tx_empty;
        v[STAT_RX_FULL]  = rx_full;
        v[STAT_RX_EMPTY] = rx_empty;
        v[STAT_BUSY]     = busy;
        v[STAT_OVR]      = ovr;
        return v;
    endfunction

endpackage

// File: rtl/spi_controller_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO used for both TX and RX byte queues.
//   Pointers carry one extra wrap bit so full and empty are unambiguous.
//   A push while full is still accepted if a pop happens in the same cycle.
//
//   i_clk    clock (rising edge)
//   i_rst    synchronous active-high reset, empties the FIFO
//   i_push   write request, i_data written when accepted
//   i_pop    read request, ignored when empty
//   o_data   head entry (valid while !o_empty)
//   o_full   no free slot
//   o_empty  no stored entry
//   o_drop   push was rejected this cycle (full and no pop)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A same-cycle pop frees the slot the push lands in.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
//   Wishbone (pipelined B4) responder driving an SPI mode 0 link, MSB first.
//   Bytes written to DATA are queued in a TX FIFO, shifted out on spi_sdo_o,
//   and the bytes captured from spi_sdi_i are queued in an RX FIFO for reading.
//
//   wb_clk_i    clock          wb_reset_i  synchronous active-high reset
//   wb_adr_i    0 DATA, 1 STATUS, 2 CONTROL, 3 reserved
//   wb_dat_i    write data     wb_dat_o    read data (valid with wb_ack_o)
//   wb_we_i     write enable   wb_cyc_i/wb_stb_i  bus request
//   wb_ack_o    acknowledge one cycle after the strobe
//   wb_stall_o  always 0
//   spi_sck_o   SPI clock, idles low
//   spi_sdo_o   controller-out data, changes with SCK falling
//   spi_sdi_i   controller-in data, sampled as SCK rises
//   spi_cs_no   chip select, active low, software controlled
// -----------------------------------------------------------------------------
module spi_controller #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 3
) (
    input  logic       wb_clk_i,
    input  logic       wb_reset_i,
    input  logic [1:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    output logic       wb_ack_o,
    output logic       wb_stall_o,
    output logic       spi_sck_o,
    output logic       spi_sdo_o,
    input  logic       spi_sdi_i,
    output logic       spi_cs_no
);

    import spi_pkg::*;

    logic       w_req;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic [7:0] w_tx_data;
    logic [7:0] w_rx_data;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_tx_drop;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_rx_drop;
    logic [7:0] w_rd_data;

    logic       r_ack;
    logic [7:0] r_dat;
    logic [3:0] r_div;
    logic       r_cs_n;
    logic       r_ovr;

    state_t     r_state;
    logic       r_sck;
    logic       r_sdo;
    logic       r_busy;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_shift;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_div_cnt;
    logic [3:0] r_div_lat;

    assign w_req     = wb_cyc_i & wb_stb_i;
    assign w_tx_push = w_req & wb_we_i & (wb_adr_i == SPI_REG_DATA);
    assign w_rx_pop  = w_req & ~wb_we_i & (wb_adr_i == SPI_REG_DATA);
    assign w_tx_pop  = (r_state == LOAD);
    assign w_rx_push = (r_state == DONE);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_reset_i),
        .i_push  (w_tx_push),
        .i_data  (wb_dat_i),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_drop  (w_tx_drop)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_reset_i),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_drop  (w_rx_drop)
    );

    // Read-data selection; an empty RX FIFO reads as zero.
    always_comb begin
        w_rd_data = 8'h00;
        case (wb_adr_i)
            SPI_REG_DATA: begin
                if (w_rx_empty) begin
                    w_rd_data = 8'h00;
                end else begin
                    w_rd_data = w_rx_data;
                end
            end
            SPI_REG_STATUS: begin
                w_rd_data = pack_status(w_tx_full, w_tx_empty, w_rx_full,
                                        w_rx_empty, r_busy, r_ovr);
            end
            SPI_REG_CONTROL: begin
                w_rd_data = {~r_cs_n, 3'b000, r_div};
            end
            default: begin
                w_rd_data = 8'h00;
            end
        endcase
    end

    // Bus response, CONTROL register and the sticky overrun flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            r_ack  <= 1'b0;
            r_dat  <= 8'h00;
            r_div  <= 4'(DIV_RESET);
            r_cs_n <= 1'b1;
            r_ovr  <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req && !wb_we_i) begin
                r_dat <= w_rd_data;
            end else begin
                r_dat <= 8'h00;
            end
            if (w_req && wb_we_i && (wb_adr_i == SPI_REG_CONTROL)) begin
                r_div  <= wb_dat_i[3:0];
                r_cs_n <= ~wb_dat_i[7];
            end
            // A new overrun wins over a same-cycle clear so no event is lost.
            if (w_tx_drop || w_rx_drop) begin
                r_ovr <= 1'b1;
            end else if (w_req && wb_we_i && (wb_adr_i == SPI_REG_STATUS) && wb_dat_i[7]) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // Byte-transfer FSM: divider, shift registers and SPI pin drivers.
    // busy is registered, so it stays high through the IDLE cycle that
    // follows DONE; a byte therefore reads busy for 16*(div+1)+3 clocks.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            r_state    <= IDLE;
            r_sck      <= 1'b0;
            r_sdo      <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_shift <= 8'h00;
            r_rx_shift <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_div_cnt  <= 4'd0;
            r_div_lat  <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sck <= 1'b0;
                    if (!w_tx_empty) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    r_tx_shift <= w_tx_data;
                    r_sdo      <= w_tx_data[7];
                    r_bit_cnt  <= 3'd7;
                    r_div_lat  <= r_div;
                    r_div_cnt  <= 4'd0;
                    r_sck      <= 1'b0;
                    r_busy     <= 1'b1;
                    r_state    <= LOW;
                end
                LOW: begin
                    if (r_div_cnt == r_div_lat) begin
                        // Rising SCK edge: capture the target's bit here.
                        r_sck      <= 1'b1;
                        r_rx_shift <= {r_rx_shift[6:0], spi_sdi_i};
                        r_div_cnt  <= 4'd0;
                        r_state    <= HIGH;
                    end else begin
                        r_div_cnt  <= r_div_cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (r_div_cnt == r_div_lat) begin
                        r_sck     <= 1'b0;
                        r_div_cnt <= 4'd0;
                        if (r_bit_cnt == 3'd0) begin
                            r_state <= DONE;
                        end else begin
                            r_bit_cnt  <= r_bit_cnt - 3'd1;
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            r_sdo      <= r_tx_shift[6];
                            r_state    <= LOW;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_sck   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_sck   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign wb_stall_o = 1'b0;
    assign spi_sck_o  = r_sck;
    assign spi_sdo_o  = r_sdo;
    assign spi_cs_no  = r_cs_n;

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
//   Scoreboard bench: every bus transfer queues its expected read value, and a
//   monitor pops and compares on each acknowledge. The reference model treats
//   the link as "each accepted byte comes back (loopback or target byte) into a
//   bounded RX queue" and derives STATUS from queue occupancy.
// -----------------------------------------------------------------------------
module tb_spi_controller;
    import spi_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       wb_reset_i = 1'b1;
    logic [1:0] wb_adr_i = 2'd0;
    logic [7:0] wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_we_i = 1'b0;
    logic       wb_cyc_i = 1'b0;
    logic       wb_stb_i = 1'b0;
    logic       wb_ack_o;
    logic       wb_stall_o;
    logic       spi_sck_o;
    logic       spi_sdo_o;
    logic       spi_sdi_i;
    logic       spi_cs_no;

    logic       sdi_mode = 1'b0;   // 0 loopback, 1 target model
    logic [7:0] tgt_shift = 8'h00;

    always #5 clk = ~clk;

    assign spi_sdi_i = sdi_mode ? tgt_shift[7] : spi_sdo_o;

    spi_controller #(.FIFO_DEPTH(DEPTH), .DIV_RESET(3)) dut (
        .wb_clk_i   (clk),
        .wb_reset_i (wb_reset_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_ack_o   (wb_ack_o),
        .wb_stall_o (wb_stall_o),
        .spi_sck_o  (spi_sck_o),
        .spi_sdo_o  (spi_sdo_o),
        .spi_sdi_i  (spi_sdi_i),
        .spi_cs_no  (spi_cs_no)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] exp;
        logic [7:0] mask;
        logic       poll;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_nm;
    int    busy_cnt = 0;
    logic  stb_prev = 1'b0;

    // Reference model state
    logic [7:0] m_rx[$];
    logic       m_ovr = 1'b0;

    // Mode-0 target: next bit appears after each SCK falling edge.
    always @(negedge spi_sck_o) tgt_shift = {tgt_shift[6:0], 1'b0};

    // SCK edge observer
    int         sck_rises = 0;
    logic [7:0] sdo_cap = 8'h00;
    time        last_rise = 0;
    time        rise_period = 0;
    always @(posedge spi_sck_o) begin
        sck_rises   = sck_rises + 1;
        sdo_cap     = {sdo_cap[6:0], spi_sdo_o};
        rise_period = $time - last_rise;
        last_rise   = $time;
    end

    always @(posedge clk) stb_prev <= wb_cyc_i & wb_stb_i & ~wb_reset_i;

    // Monitor: ack latency plus scoreboard compare of read data.
    always @(negedge clk) begin
        if (stb_prev || wb_ack_o) begin
            checks = checks + 1;
            if (wb_ack_o !== stb_prev) begin
                errors = errors + 1;
                $display("FAIL ack_timing: ack=%0b expected=%0b at %0t", wb_ack_o, stb_prev, $time);
            end
        end
        if (wb_ack_o) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_ack at %0t", $time);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                if (mon_e.poll && wb_dat_o[STAT_BUSY]) busy_cnt = busy_cnt + 1;
                if (mon_e.mask != 8'h00) begin
                    checks = checks + 1;
                    if ((wb_dat_o & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
                        errors = errors + 1;
                        $display("FAIL %s: got %02h expected %02h (mask %02h)",
                                 mon_nm, wb_dat_o, mon_e.exp, mon_e.mask);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic [1:0] adr, input logic we, input logic [7:0] dat,
                       input logic [7:0] exp, input logic [7:0] mask, input logic poll,
                       input string nm);
        exp_t e;
        e.exp = exp; e.mask = mask; e.poll = poll;
        exp_q.push_back(e);
        name_q.push_back(nm);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_adr_i = adr;  wb_we_i  = we; wb_dat_i = dat;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] dat);
        bus(adr, 1'b1, dat, 8'h00, 8'h00, 1'b0, "write");
    endtask

    task automatic rd(input logic [1:0] adr, input logic [7:0] exp, input string nm);
        bus(adr, 1'b0, 8'h00, exp, 8'hFF, 1'b0, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k = k + 1;
        end
        check("scoreboard_drain", exp_q.size(), 0);
    endtask

    function automatic int byte_time(input int div);
        return 16 * (div + 1) + 3;
    endfunction

    // Model: a completed byte enters RX unless RX already holds DEPTH bytes.
    task automatic model_rx(input logic [7:0] b);
        if (m_rx.size() < DEPTH) m_rx.push_back(b);
        else m_ovr = 1'b1;
    endtask

    function automatic logic [7:0] model_status(input int tx_n, input logic busy);
        return pack_status(tx_n == DEPTH, tx_n == 0, m_rx.size() == DEPTH,
                           m_rx.size() == 0, busy, m_ovr);
    endfunction

    task automatic read_rx(input string nm);
        logic [7:0] b;
        if (m_rx.size() == 0) b = 8'h00;
        else b = m_rx.pop_front();
        rd(SPI_REG_DATA, b, nm);
    endtask

    initial begin
        // 1. Reset state
        idle(3);
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_sck", spi_sck_o, 0);
        check("rst_sdo", spi_sdo_o, 0);
        check("rst_csn", spi_cs_no, 1);
        wb_reset_i = 1'b0;
        idle(1);
        rd(SPI_REG_STATUS, 8'h0A, "rst_status");
        rd(SPI_REG_CONTROL, 8'h03, "rst_control");
        drain();

        // 2. Loopback byte at div=3, busy duration and bit order
        wr(SPI_REG_CONTROL, 8'h83);
        sck_rises = 0;
        busy_cnt  = 0;
        wr(SPI_REG_DATA, 8'hA5);
        check("cs_asserted", spi_cs_no, 0);
        for (int i = 0; i < 80; i++) bus(SPI_REG_STATUS, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, "poll");
        drain();
        model_rx(8'hA5);
        check("busy_clocks", busy_cnt, byte_time(3));
        check("sck_rises", sck_rises, 8);
        check("sdo_bits", sdo_cap, 8'hA5);
        read_rx("loop_a5");
        drain();

        // 3. div=0 against target returning 0xC3
        wr(SPI_REG_CONTROL, 8'h80);
        tgt_shift = 8'hC3;
        sdi_mode  = 1'b1;
        wr(SPI_REG_DATA, 8'h3C);
        idle(byte_time(0) + 5);
        model_rx(8'hC3);
        check("sck_period", int'(rise_period), 20);
        read_rx("target_c3");
        drain();
        sdi_mode = 1'b0;

        // 5. Empty RX reads, back-to-back strobes
        rd(SPI_REG_STATUS, model_status(0, 1'b0), "status_before");
        read_rx("empty_read0");
        read_rx("empty_read1");
        rd(SPI_REG_STATUS, model_status(0, 1'b0), "status_after");
        drain();

        // 4. TX overflow with div=0
        for (int i = 1; i <= 6; i++) wr(SPI_REG_DATA, 8'(i));
        m_ovr = 1'b1;
        rd(SPI_REG_STATUS, model_status(DEPTH, 1'b1), "ovr_tx_full");
        wr(SPI_REG_STATUS, 8'h80);
        m_ovr = 1'b0;
        rd(SPI_REG_STATUS, model_status(DEPTH, 1'b1), "ovr_cleared");
        idle(5 * byte_time(0) + 10);
        for (int i = 1; i <= 5; i++) model_rx(8'(i));
        rd(SPI_REG_STATUS, model_status(0, 1'b0), "rx_overrun");
        for (int i = 0; i < 5; i++) read_rx("ovr_data");
        wr(SPI_REG_STATUS, 8'h80);
        m_ovr = 1'b0;
        rd(SPI_REG_STATUS, model_status(0, 1'b0), "ovr_final");
        drain();

        // Randomized loopback bursts
        for (int it = 0; it < 6; it++) begin
            int div;
            int n;
            logic [7:0] b;
            div = int'($urandom_range(0, 3));
            n   = int'($urandom_range(1, 4));
            wr(SPI_REG_CONTROL, {1'b1, 3'b000, 4'(div)});
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                wr(SPI_REG_DATA, b);
                model_rx(b);
            end
            idle(n * byte_time(div) + 8);
            rd(SPI_REG_STATUS, model_status(0, 1'b0), "rand_status");
            for (int j = 0; j <= n; j++) read_rx("rand_data");
            drain();
        end

        // 6. Reset during bit 4
        wr(SPI_REG_CONTROL, 8'h83);
        sck_rises = 0;
        wr(SPI_REG_DATA, 8'h5A);
        wr(SPI_REG_DATA, 8'h77);
        drain();
        begin
            int k;
            k = 0;
            while (sck_rises < 4 && k < 200) begin
                @(posedge clk); #1;
                k = k + 1;
            end
            check("reach_bit4", int'(sck_rises >= 4), 1);
        end
        idle(2);
        wb_reset_i = 1'b1;
        @(posedge clk); #1;
        check("midrst_sck", spi_sck_o, 0);
        check("midrst_csn", spi_cs_no, 1);
        wb_reset_i = 1'b0;
        m_rx.delete();
        m_ovr = 1'b0;
        rd(SPI_REG_CONTROL, 8'h03, "midrst_control");
        rd(SPI_REG_STATUS, model_status(0, 1'b0), "midrst_status");
        idle(2 * byte_time(3) + 10);
        rd(SPI_REG_STATUS, model_status(0, 1'b0), "midrst_no_push");
        read_rx("midrst_rx_empty");
        drain();
        check("stall_low", wb_stall_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
